// File: rtl/axis_pkt_gen.sv
// axis_pkt_gen: AXI-Stream master producing framed test traffic.
// A run is num_pkts packets of pkt_len beats each. Data increments by one
// per accepted beat starting at seed, tlast marks the final beat of each
// packet, and an optional idle gap separates consecutive packets.
`timescale 1ns/1ps
module axis_pkt_gen #(
   parameter int data_width = 16,
   parameter int len_width  = 12,
   parameter int cnt_width  = 8,
   parameter int gap_width  = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [len_width-1:0]  pkt_len,
   input  logic [cnt_width-1:0]  num_pkts,
   input  logic [gap_width-1:0]  gap,
   input  logic [data_width-1:0] seed,
   output logic [data_width-1:0] m_axis_tdata,
   output logic                  m_axis_tvalid,
   output logic                  m_axis_tlast,
   input  logic                  m_axis_tready,
   output logic                  busy,
   output logic                  done,
   output logic [cnt_width-1:0]  pkt_count
);

   typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

   localparam logic [data_width-1:0] data_one = 1;
   localparam logic [len_width-1:0]  len_one  = 1;
   localparam logic [cnt_width-1:0]  cnt_one  = 1;
   localparam logic [gap_width-1:0]  gap_one  = 1;

   state_t                 state;
   logic [len_width-1:0]   len_q;
   logic [cnt_width-1:0]   num_q;
   logic [gap_width-1:0]   gap_q;
   logic [len_width-1:0]   beat;
   logic [gap_width-1:0]   gap_cnt;

   logic [data_width-1:0]  tdata_nxt;
   logic [len_width-1:0]   beat_nxt;
   logic [len_width-1:0]   len_last;
   logic [cnt_width-1:0]   cnt_nxt;
   logic                   handshake;

   // Incremented/derived values shared by the state machine.
   always_comb begin
      tdata_nxt = m_axis_tdata + data_one;
      beat_nxt  = beat + len_one;
      len_last  = len_q - len_one;
      cnt_nxt   = pkt_count + cnt_one;
      handshake = m_axis_tvalid && m_axis_tready;
   end

   // Run control FSM; every output is a register so tvalid never follows tready combinationally.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state         <= IDLE;
         len_q         <= '0;
         num_q         <= '0;
         gap_q         <= '0;
         beat          <= '0;
         gap_cnt       <= '0;
         m_axis_tdata  <= '0;
         m_axis_tvalid <= 1'b0;
         m_axis_tlast  <= 1'b0;
         busy          <= 1'b0;
         done          <= 1'b0;
         pkt_count     <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               // A zero length or zero count request is not a run at all.
               if (start && (pkt_len != '0) && (num_pkts != '0)) begin
                  len_q         <= pkt_len;
                  num_q         <= num_pkts;
                  gap_q         <= gap;
                  beat          <= '0;
                  pkt_count     <= '0;
                  m_axis_tdata  <= seed;
                  m_axis_tvalid <= 1'b1;
                  m_axis_tlast  <= (pkt_len == len_one);
                  busy          <= 1'b1;
                  state         <= SEND;
               end
            end
            SEND: begin
               // Outputs only move on a handshake, which keeps a stalled beat stable.
               if (handshake) begin
                  m_axis_tdata <= tdata_nxt;
                  if (m_axis_tlast) begin
                     beat      <= '0;
                     pkt_count <= cnt_nxt;
                     if (cnt_nxt == num_q) begin
                        m_axis_tvalid <= 1'b0;
                        m_axis_tlast  <= 1'b0;
                        busy          <= 1'b0;
                        done          <= 1'b1;
                        state         <= IDLE;
                     end else if (gap_q == '0) begin
                        m_axis_tlast <= (len_q == len_one);
                     end else begin
                        m_axis_tvalid <= 1'b0;
                        m_axis_tlast  <= 1'b0;
                        gap_cnt       <= gap_q;
                        state         <= GAP;
                     end
                  end else begin
                     beat         <= beat_nxt;
                     m_axis_tlast <= (beat_nxt == len_last);
                  end
               end
            end
            GAP: begin
               // Leaving on a count of 1 makes tvalid low for exactly gap cycles.
               if (gap_cnt == gap_one) begin
                  m_axis_tvalid <= 1'b1;
                  m_axis_tlast  <= (len_q == len_one);
                  state         <= SEND;
               end else begin
                  gap_cnt <= gap_cnt - gap_one;
               end
            end
            default: begin
               state         <= IDLE;
               m_axis_tvalid <= 1'b0;
               m_axis_tlast  <= 1'b0;
               busy          <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_axis_pkt_gen.sv
// Scoreboard bench for axis_pkt_gen: each accepted run pushes its expected
// beats, computed directly from seed/len/count, and a negedge monitor pops
// and compares every handshake, plus stall stability and done timing.
`timescale 1ns/1ps
module tb_axis_pkt_gen;
   localparam int DW = 16;
   localparam int LW = 12;
   localparam int CW = 8;
   localparam int GW = 8;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          start = 1'b0;
   logic [LW-1:0] pkt_len = '0;
   logic [CW-1:0] num_pkts = '0;
   logic [GW-1:0] gap = '0;
   logic [DW-1:0] seed = '0;
   logic [DW-1:0] tdata;
   logic          tvalid;
   logic          tlast;
   logic          tready = 1'b0;
   logic          busy;
   logic          done;
   logic [CW-1:0] pkt_count;

   typedef struct packed {
      logic [DW-1:0] data;
      logic          last;
      logic          fin;
   } beat_t;

   beat_t         exp_q[$];
   beat_t         b;
   int            checks = 0;
   int            errors = 0;
   int            ready_pct = 100;
   int            busy_cycles = 0;
   int            gap_cycles = 0;
   int            stall_cycles = 0;
   bit            exp_done_next = 1'b0;
   bit            prev_stall = 1'b0;
   logic [DW-1:0] prev_data = '0;
   logic          prev_last = 1'b0;

   axis_pkt_gen #(
      .data_width(DW), .len_width(LW), .cnt_width(CW), .gap_width(GW)
   ) dut (
      .clk(clk), .reset(reset), .start(start), .pkt_len(pkt_len),
      .num_pkts(num_pkts), .gap(gap), .seed(seed),
      .m_axis_tdata(tdata), .m_axis_tvalid(tvalid), .m_axis_tlast(tlast),
      .m_axis_tready(tready), .busy(busy), .done(done), .pkt_count(pkt_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference: beat k of the run carries seed+k, tlast every len beats.
   task automatic model_run(input logic [DW-1:0] s, input int len, input int n);
      beat_t e;
      for (int p = 0; p < n; p++) begin
         for (int k = 0; k < len; k++) begin
            e.data = s + DW'(p * len + k);
            e.last = (k == len - 1);
            e.fin  = (p == n - 1) && (k == len - 1);
            exp_q.push_back(e);
         end
      end
   endtask

   // Downstream ready generator.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         tready = ($urandom_range(99) < ready_pct);
      end
   end

   // Monitor: compares handshakes, stall stability and done timing.
   always @(negedge clk) begin
      if (reset) begin
         exp_done_next = 1'b0;
         prev_stall    = 1'b0;
      end else begin
         chk("done_timing", 32'(done), 32'(exp_done_next));
         exp_done_next = 1'b0;
         if (prev_stall) begin
            chk("stall_valid", 32'(tvalid), 32'd1);
            chk("stall_data", 32'(tdata), 32'(prev_data));
            chk("stall_last", 32'(tlast), 32'(prev_last));
         end
         if (!tvalid) chk("idle_tlast", 32'(tlast), 32'd0);
         if (tvalid && tready) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_beat: got data 0x%0h expected no beat", tdata);
            end else begin
               b = exp_q.pop_front();
               chk("beat_data", 32'(tdata), 32'(b.data));
               chk("beat_last", 32'(tlast), 32'(b.last));
               if (b.fin) exp_done_next = 1'b1;
            end
         end
         if (busy) busy_cycles++;
         if (busy && !tvalid) gap_cycles++;
         if (tvalid && !tready) stall_cycles++;
         prev_stall = tvalid && !tready;
         prev_data  = tdata;
         prev_last  = tlast;
      end
   end

   task automatic run(input logic [DW-1:0] s, input int len, input int n, input int g,
                      input int pct, input bit poke);
      int t;
      @(posedge clk);
      #1;
      ready_pct    = pct;
      busy_cycles  = 0;
      gap_cycles   = 0;
      stall_cycles = 0;
      seed     = s;
      pkt_len  = LW'(len);
      num_pkts = CW'(n);
      gap      = GW'(g);
      start    = 1'b1;
      model_run(s, len, n);
      @(posedge clk);
      #1;
      start    = 1'b0;
      seed     = DW'($urandom);
      pkt_len  = LW'($urandom);
      num_pkts = CW'($urandom);
      gap      = GW'($urandom);
      chk("first_valid", 32'(tvalid), 32'd1);
      chk("first_data", 32'(tdata), 32'(s));
      chk("busy_rise", 32'(busy), 32'd1);
      if (poke) begin
         repeat (3) @(posedge clk);
         #1;
         start = 1'b1;
         @(posedge clk);
         #1;
         start = 1'b0;
      end
      t = 0;
      while (!done && t < 5000) begin
         @(negedge clk);
         t++;
      end
      if (!done) begin
         checks++;
         errors++;
         $display("FAIL run_timeout: got no done after %0d cycles expected done", t);
      end else begin
         chk("pkt_count", 32'(pkt_count), 32'(n));
         chk("busy_fall", 32'(busy), 32'd0);
         chk("valid_fall", 32'(tvalid), 32'd0);
         chk("queue_empty", 32'(exp_q.size()), 32'd0);
         chk("busy_cycles", 32'(busy_cycles), 32'(n * len + (n - 1) * g + stall_cycles));
         chk("gap_cycles", 32'(gap_cycles), 32'((n - 1) * g));
      end
      @(negedge clk);
      chk("pkt_count_hold", 32'(pkt_count), 32'(n));
   endtask

   task automatic bad_start(input int len, input int n);
      @(posedge clk);
      #1;
      pkt_len  = LW'(len);
      num_pkts = CW'(n);
      gap      = '0;
      seed     = 16'h1234;
      start    = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (4) begin
         @(negedge clk);
         chk("ignored_valid", 32'(tvalid), 32'd0);
         chk("ignored_busy", 32'(busy), 32'd0);
      end
   endtask

   initial begin
      int t;
      #1;
      chk("rst_tdata", 32'(tdata), 32'd0);
      chk("rst_tvalid", 32'(tvalid), 32'd0);
      chk("rst_tlast", 32'(tlast), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_pkt_count", 32'(pkt_count), 32'd0);
      repeat (2) @(negedge clk);
      #2;
      reset = 1'b0;

      run(16'h0010, 4, 1, 0, 100, 1'b0);
      run(16'h0000, 3, 3, 2, 100, 1'b0);
      run(16'h0000, 5, 4, 0, 50, 1'b0);
      run(16'hFFFE, 4, 1, 0, 100, 1'b0);
      bad_start(0, 3);
      bad_start(5, 0);
      run(16'h0200, 5, 4, 1, 100, 1'b1);

      // Reset in the middle of a 6-beat packet.
      @(posedge clk);
      #1;
      ready_pct = 100;
      seed = 16'h0100; pkt_len = 6; num_pkts = 1; gap = 0;
      start = 1'b1;
      model_run(16'h0100, 6, 1);
      @(posedge clk);
      #1;
      start = 1'b0;
      t = 0;
      while (!(tvalid && tdata == 16'h0102) && t < 100) begin
         @(negedge clk);
         t++;
      end
      chk("reach_beat2", 32'(tdata), 32'h0102);
      #2;
      reset = 1'b1;
      #1;
      chk("midrst_tvalid", 32'(tvalid), 32'd0);
      chk("midrst_tdata", 32'(tdata), 32'd0);
      chk("midrst_busy", 32'(busy), 32'd0);
      chk("midrst_done", 32'(done), 32'd0);
      chk("midrst_pkt_count", 32'(pkt_count), 32'd0);
      exp_q.delete();
      repeat (2) @(negedge clk);
      #2;
      reset = 1'b0;
      repeat (3) begin
         @(negedge clk);
         chk("post_rst_valid", 32'(tvalid), 32'd0);
      end
      run(16'h0100, 6, 1, 0, 100, 1'b0);

      for (int i = 0; i < 6; i++) begin
         run(DW'($urandom), $urandom_range(1, 8), $urandom_range(1, 4),
             $urandom_range(0, 3), 60, 1'b0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got no finish expected finish before time limit");
      $fatal(1, "watchdog");
   end

endmodule
